// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the load/store unit (master) and the data memory (slave).
// Handshake: req held until gnt, then one rvalid carries the read word.
interface mem_stage_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                    mem_req_o;
    logic                    mem_we_o;
    logic [DATA_WIDTH/8-1:0] mem_be_o;
    logic [ADDR_WIDTH-1:0]   mem_addr_o;
    logic [DATA_WIDTH-1:0]   mem_wdata_o;
    logic                    mem_gnt_i;
    logic                    mem_rvalid_i;
    logic [DATA_WIDTH-1:0]   mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one outstanding access over a variable-latency req/gnt/rvalid bus,
// with lane alignment, load extension, misalign rejection, grant-to-rvalid timeout and flush.
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 16,
    parameter int RD_BITS    = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [RD_BITS-1:0]    req_rd_i,
    input  logic                  flush_i,
    mem_stage_lsu_if.master       mem,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [RD_BITS-1:0]    resp_rd_o,
    output logic                  misalign_o,
    output logic                  bus_err_o,
    output logic                  stall_o
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t                r_state, w_state_nxt;
    logic                  r_we, r_unsigned, r_misalign;
    logic [1:0]            r_size;
    logic [LB-1:0]         r_off;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [NB-1:0]         r_be;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [RD_BITS-1:0]    r_rd;
    logic [CW-1:0]         r_cnt;

    logic [LB-1:0]         w_off;
    logic                  w_bad, w_accept, w_timeout, w_resp_valid, w_bus_err, w_sign;
    logic [15:0]           w_be_mask;
    logic [DATA_WIDTH-1:0] w_shift, w_keep, w_ext;
    logic [CW-1:0]         w_cnt_inc;

    assign w_off     = req_addr_i[LB-1:0];
    assign w_be_mask = (16'd1 << (5'd1 << req_size_i)) - 16'd1;
    assign w_accept  = (r_state == S_IDLE) && req_valid_i && !w_bad;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (w_cnt_inc == CW'(TIMEOUT));

    always_comb begin
        w_bad = 1'b0;
        case (req_size_i)
            2'd1:    w_bad = req_addr_i[0];
            2'd2:    w_bad = |req_addr_i[1:0];
            2'd3:    w_bad = (DATA_WIDTH == 32) || (|req_addr_i[2:0]);
            default: w_bad = 1'b0;
        endcase
    end

    // Load result: move the addressed lane down to bit 0, then fill above the access width.
    assign w_shift = mem.mem_rdata_i >> {r_off, 3'b000};
    always_comb begin
        w_keep = '1;
        w_sign = w_shift[DATA_WIDTH-1];
        case (r_size)
            2'd0:    begin w_keep = DATA_WIDTH'(8'hFF);         w_sign = w_shift[7];  end
            2'd1:    begin w_keep = DATA_WIDTH'(16'hFFFF);      w_sign = w_shift[15]; end
            2'd2:    begin w_keep = DATA_WIDTH'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
            default: begin w_keep = '1;                         w_sign = w_shift[DATA_WIDTH-1]; end
        endcase
    end
    assign w_ext = (w_shift & w_keep) | ({DATA_WIDTH{w_sign & ~r_unsigned}} & ~w_keep);

    always_comb begin
        w_state_nxt  = r_state;
        w_resp_valid = 1'b0;
        w_bus_err    = 1'b0;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_REQ;
            S_REQ: begin
                if (mem.mem_gnt_i)  w_state_nxt = flush_i ? S_DRAIN : S_WAIT;
                else if (flush_i)   w_state_nxt = S_IDLE;
            end
            // rvalid outranks the timeout; a flush turns the wait into a silent drain.
            S_WAIT: begin
                if (flush_i) begin
                    w_state_nxt = (mem.mem_rvalid_i || w_timeout) ? S_IDLE : S_DRAIN;
                end else if (mem.mem_rvalid_i) begin
                    w_state_nxt = S_RESP;
                end else if (w_timeout) begin
                    w_bus_err   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                w_resp_valid = !flush_i;
                w_state_nxt  = S_IDLE;
            end
            S_DRAIN: if (mem.mem_rvalid_i || w_timeout) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_unsigned <= 1'b0;
            r_misalign <= 1'b0;
            r_size     <= '0;
            r_off      <= '0;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_misalign <= (r_state == S_IDLE) && req_valid_i && w_bad;
            if (w_accept) begin
                r_we       <= req_we_i;
                r_unsigned <= req_unsigned_i;
                r_size     <= req_size_i;
                r_off      <= w_off;
                r_addr     <= {req_addr_i[ADDR_WIDTH-1:LB], {LB{1'b0}}};
                r_be       <= NB'(w_be_mask << w_off);
                r_wdata    <= req_wdata_i << {w_off, 3'b000};
                r_rd       <= req_rd_i;
            end
            if (r_state == S_REQ && mem.mem_gnt_i) r_cnt <= '0;
            else if (r_state == S_WAIT || r_state == S_DRAIN) r_cnt <= w_cnt_inc;
            if (r_state == S_WAIT && mem.mem_rvalid_i) r_rdata <= r_we ? '0 : w_ext;
        end
    end

    assign mem.mem_req_o   = (r_state == S_REQ);
    assign mem.mem_we_o    = (r_state == S_REQ) && r_we;
    assign mem.mem_be_o    = (r_state == S_REQ) ? r_be : '0;
    assign mem.mem_addr_o  = r_addr;
    assign mem.mem_wdata_o = r_wdata;

    assign req_ready_o  = (r_state == S_IDLE);
    assign stall_o      = (r_state != S_IDLE);
    assign resp_valid_o = w_resp_valid;
    assign resp_rdata_o = w_resp_valid ? r_rdata : '0;
    assign resp_rd_o    = (w_resp_valid && !r_we) ? r_rd : '0;
    assign misalign_o   = r_misalign;
    assign bus_err_o    = w_bus_err;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu: a reactive memory responder drives the bus and each
// operation's outcome is predicted from the access rules, then compared per window.
module tb_mem_stage_lsu;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 4;
    localparam int RB = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid_i, req_ready_o, req_we_i, req_unsigned_i, flush_i;
    logic [1:0]    req_size_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i, resp_rdata_o;
    logic [RB-1:0] req_rd_i, resp_rd_o;
    logic          resp_valid_o, misalign_o, bus_err_o, stall_o;

    mem_stage_lsu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mif ();

    mem_stage_lsu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO), .RD_BITS(RB)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i), .req_rd_i(req_rd_i), .flush_i(flush_i), .mem(mif),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_rd_o(resp_rd_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o), .stall_o(stall_o)
    );

    // 64-bit instance for double-word and extended-word loads
    logic          w_valid, w_ready, w_we, w_uns, w_flush, w_rvld, w_mis, w_berr, w_stall;
    logic [1:0]    w_size;
    logic [AW-1:0] w_addr;
    logic [63:0]   w_wdata, w_rdata;
    logic [RB-1:0] w_rd_in, w_rd;

    mem_stage_lsu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(AW)) mif64 ();

    mem_stage_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(AW), .TIMEOUT(16), .RD_BITS(RB)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid_i(w_valid), .req_ready_o(w_ready), .req_we_i(w_we),
        .req_size_i(w_size), .req_unsigned_i(w_uns), .req_addr_i(w_addr),
        .req_wdata_i(w_wdata), .req_rd_i(w_rd_in), .flush_i(w_flush), .mem(mif64),
        .resp_valid_o(w_rvld), .resp_rdata_o(w_rdata), .resp_rd_o(w_rd),
        .misalign_o(w_mis), .bus_err_o(w_berr), .stall_o(w_stall)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_misaligned(input logic [1:0] sz, input logic [31:0] a);
        return ((a % (32'd1 << sz)) != 0) || (sz == 2'd3);
    endfunction

    function automatic logic [31:0] m_be(input logic [1:0] sz, input logic [31:0] a);
        int n = 1 << sz;
        return ((32'd1 << n) - 32'd1) << (a % 4);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] sz,
                                           input logic uns, input logic [31:0] a);
        logic [63:0] v, m;
        int nb = 8 << sz;
        v = {32'd0, rd} >> (8 * (a % 4));
        m = (64'd1 << nb) - 64'd1;
        v = v & m;
        if (!uns && v[nb-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // One operation on the 32-bit unit; fc = cycle on which flush_i pulses (-1 = none).
    task automatic run_case(input string nm, input logic we, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input logic [4:0] rd, input int g, input int r, input int fc,
                            input logic [31:0] rdat,
                            output logic [31:0] o_data, output logic [31:0] o_be,
                            output logic [31:0] o_wd);
        bit   mis = m_misaligned(sz, a);
        bit   late = (r > TO);
        bit   drained = 1'b0;
        int   gc = 1 + g;
        int   tc = gc + TO;
        int   rvc = late ? tc + 2 : gc + r;
        int   e_req = 0, e_busy = 0, e_resp = 0, e_rcyc = 0, e_berr = 0, e_bcyc = 0, win;
        int   n_req = 0, n_badreq = 0, n_busy = 0, n_stall = 0, n_resp = 0, n_berr = 0, n_mis = 0;
        int   rcyc = -1, bcyc = -1, mcyc = -1, seen = 0, gcyc = -1;
        logic [31:0] e_wd = wd << (8 * (a % 4));
        logic [31:0] e_bev = m_be(sz, a);
        logic [31:0] r_data = '0;
        logic [4:0]  r_rd = '0;
        o_be = '0;
        o_wd = '0;

        if (mis) begin
            win = 4;
        end else if (fc >= 1 && fc < gc) begin
            e_req = fc; e_busy = fc;
        end else if (fc >= gc && fc < (late ? tc : rvc)) begin
            e_req = g + 1; e_busy = late ? tc : rvc; drained = 1'b1;
        end else if (!late && fc == rvc + 1) begin
            e_req = g + 1; e_busy = rvc + 1;
        end else if (late) begin
            e_req = g + 1; e_busy = tc; e_berr = 1; e_bcyc = tc;
        end else begin
            e_req = g + 1; e_busy = rvc + 1; e_resp = 1; e_rcyc = rvc + 1;
        end
        if (!mis) win = (late ? tc + 3 : rvc + 1) + 3;

        for (int c = 0; c <= win; c++) begin
            @(negedge clk);
            req_valid_i    = (c == 0);
            req_we_i       = we;
            req_size_i     = sz;
            req_unsigned_i = uns;
            req_addr_i     = a;
            req_wdata_i    = wd;
            req_rd_i       = rd;
            flush_i        = (c == fc);
            mif.mem_gnt_i  = mif.mem_req_o && (seen == g);
            if (mif.mem_req_o) seen++;
            if (mif.mem_gnt_i) gcyc = c;
            mif.mem_rvalid_i = (gcyc >= 0) && (c == gcyc + (late ? TO + 2 : r));
            mif.mem_rdata_i  = mif.mem_rvalid_i ? rdat : $urandom;
            #1;
            if (mif.mem_req_o) begin
                n_req++;
                if (mif.mem_addr_o !== {a[31:2], 2'b00} || {28'd0, mif.mem_be_o} !== e_bev ||
                    mif.mem_wdata_o !== e_wd || mif.mem_we_o !== we)
                    n_badreq++;
                if (n_req == 1) begin
                    o_be = {28'd0, mif.mem_be_o};
                    o_wd = mif.mem_wdata_o;
                end
            end
            if (!req_ready_o) n_busy++;
            if (stall_o) n_stall++;
            if (resp_valid_o) begin
                n_resp++; rcyc = c; r_data = resp_rdata_o; r_rd = resp_rd_o;
            end
            if (bus_err_o) begin n_berr++; bcyc = c; end
            if (misalign_o) begin n_mis++; mcyc = c; end
        end
        o_data = r_data;

        chk({nm, ".mis_n"}, 64'(n_mis), 64'(mis));
        if (mis) chk({nm, ".mis_cyc"}, 64'(mcyc), 64'd1);
        chk({nm, ".req_n"}, 64'(n_req), 64'(e_req));
        chk({nm, ".req_fields"}, 64'(n_badreq), 64'd0);
        chk({nm, ".busy_n"}, 64'(n_busy), 64'(e_busy));
        if (!drained) chk({nm, ".stall_n"}, 64'(n_stall), 64'(e_busy));
        chk({nm, ".resp_n"}, 64'(n_resp), 64'(e_resp));
        if (e_resp != 0) begin
            chk({nm, ".resp_cyc"}, 64'(rcyc), 64'(e_rcyc));
            chk({nm, ".resp_data"}, 64'(r_data), 64'(we ? 32'd0 : m_load(rdat, sz, uns, a)));
            chk({nm, ".resp_rd"}, 64'(r_rd), 64'(we ? 5'd0 : rd));
        end
        chk({nm, ".berr_n"}, 64'(n_berr), 64'(e_berr));
        if (e_berr != 0) chk({nm, ".berr_cyc"}, 64'(bcyc), 64'(e_bcyc));
    endtask

    task automatic run64(input string nm, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [63:0] rdat,
                         input logic [7:0] e_be, input logic [63:0] e_data);
        @(negedge clk);
        w_valid = 1'b1; w_we = 1'b0; w_size = sz; w_uns = uns; w_addr = a;
        w_wdata = '0; w_rd_in = 5'd7; w_flush = 1'b0;
        mif64.mem_gnt_i = 1'b0; mif64.mem_rvalid_i = 1'b0; mif64.mem_rdata_i = '0;
        @(negedge clk);
        w_valid = 1'b0;
        mif64.mem_gnt_i = 1'b1;
        #1;
        chk({nm, ".req"}, 64'(mif64.mem_req_o), 64'd1);
        chk({nm, ".be"}, 64'(mif64.mem_be_o), 64'(e_be));
        chk({nm, ".addr"}, 64'(mif64.mem_addr_o), 64'({a[31:3], 3'b000}));
        @(negedge clk);
        mif64.mem_gnt_i = 1'b0; mif64.mem_rvalid_i = 1'b1; mif64.mem_rdata_i = rdat;
        @(negedge clk);
        mif64.mem_rvalid_i = 1'b0; mif64.mem_rdata_i = '0;
        #1;
        chk({nm, ".resp_valid"}, 64'(w_rvld), 64'd1);
        chk({nm, ".resp_data"}, w_rdata, e_data);
        chk({nm, ".misalign"}, 64'(w_mis), 64'd0);
    endtask

    initial begin
        logic [31:0] d, be, wdo, rdat, a, wd;
        logic [1:0]  sz;
        bit          mis;
        int          g, r, fc, gc, lim;

        req_valid_i = 0; req_we_i = 0; req_size_i = 0; req_unsigned_i = 0;
        req_addr_i = 0; req_wdata_i = 0; req_rd_i = 0; flush_i = 0;
        mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0; mif.mem_rdata_i = 0;
        w_valid = 0; w_we = 0; w_size = 0; w_uns = 0; w_addr = 0; w_wdata = 0;
        w_rd_in = 0; w_flush = 0;
        mif64.mem_gnt_i = 0; mif64.mem_rvalid_i = 0; mif64.mem_rdata_i = 0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst.ready", 64'(req_ready_o), 64'd1);
        chk("rst.mem_req", 64'(mif.mem_req_o), 64'd0);
        chk("rst.stall", 64'(stall_o), 64'd0);
        chk("rst.resp", 64'(resp_valid_o), 64'd0);
        chk("rst.flags", 64'({misalign_o, bus_err_o}), 64'd0);
        chk("rst.be", 64'(mif.mem_be_o), 64'd0);
        chk("rst.ready64", 64'(w_ready), 64'd1);
        rst = 1'b1;

        rdat = 32'h80F1_7F82;
        run_case("lb",  0, 2'd0, 0, 32'h100, 0, 5'd3, 0, 1, -1, rdat, d, be, wdo);
        chk("lb.const", 64'(d), 64'h0000_0000_FFFF_FF82);
        run_case("lbu", 0, 2'd0, 1, 32'h101, 0, 5'd4, 0, 1, -1, rdat, d, be, wdo);
        chk("lbu.const", 64'(d), 64'h0000_007F);
        run_case("lh",  0, 2'd1, 0, 32'h102, 0, 5'd5, 0, 1, -1, rdat, d, be, wdo);
        chk("lh.const", 64'(d), 64'hFFFF_80F1);
        run_case("lw",  0, 2'd2, 0, 32'h100, 0, 5'd6, 0, 1, -1, rdat, d, be, wdo);
        chk("lw.const", 64'(d), 64'h80F1_7F82);
        run_case("sb",  1, 2'd0, 0, 32'h103, 32'hAB, 5'd9, 0, 1, -1, rdat, d, be, wdo);
        chk("sb.be", 64'(be), 64'h8);
        chk("sb.wdata", 64'(wdo), 64'hAB00_0000);
        run_case("sh",  1, 2'd1, 0, 32'h102, 32'h1234, 5'd9, 0, 1, -1, rdat, d, be, wdo);
        chk("sh.be", 64'(be), 64'hC);
        chk("sh.wdata", 64'(wdo), 64'h1234_0000);
        run_case("mis_lw", 0, 2'd2, 0, 32'h102, 0, 5'd1, 0, 1, -1, rdat, d, be, wdo);
        run_case("mis_sz3", 0, 2'd3, 0, 32'h100, 0, 5'd1, 0, 1, -1, rdat, d, be, wdo);
        run_case("varlat", 0, 2'd2, 0, 32'h200, 0, 5'd2, 3, 5, -1, 32'h1357_9BDF, d, be, wdo);
        run_case("timeout", 0, 2'd2, 0, 32'h204, 0, 5'd2, 0, 99, -1, 32'h1111_2222, d, be, wdo);
        run_case("after_to", 0, 2'd1, 1, 32'h206, 0, 5'd8, 0, 1, -1, 32'hBEEF_0000, d, be, wdo);
        run_case("rv_at_to", 0, 2'd2, 0, 32'h208, 0, 5'd2, 1, TO, -1, 32'h0F0F_0F0F, d, be, wdo);
        run_case("fl_wait", 0, 2'd2, 0, 32'h20C, 0, 5'd2, 0, 3, 2, 32'hCAFE_F00D, d, be, wdo);
        run_case("fl_req", 0, 2'd2, 0, 32'h210, 0, 5'd2, 3, 1, 2, 32'hCAFE_F00D, d, be, wdo);
        run_case("fl_gnt", 1, 2'd2, 0, 32'h214, 32'h55, 5'd2, 1, 2, 2, 32'h0, d, be, wdo);
        run_case("fl_resp", 0, 2'd0, 0, 32'h215, 0, 5'd2, 0, 1, 3, 32'hFFFF_FFFF, d, be, wdo);

        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) sz = 2'd3;
            a  = $urandom;
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            wd = $urandom;
            g  = $urandom_range(0, 3);
            r  = $urandom_range(1, 6);
            mis = m_misaligned(sz, a);
            fc = -1;
            if (!mis && $urandom_range(0, 3) == 0) begin
                gc  = 1 + g;
                lim = (r > TO) ? gc + TO - 1 : gc + r + 1;
                fc  = $urandom_range(1, lim);
                if (r <= TO && fc == gc + r) fc = -1;
            end
            run_case("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, wd,
                     5'($urandom), g, r, fc, $urandom, d, be, wdo);
        end

        // reset while a request waits for grant
        @(negedge clk);
        req_valid_i = 1'b1; req_we_i = 0; req_size_i = 2'd2; req_addr_i = 32'h300;
        flush_i = 0; mif.mem_gnt_i = 0; mif.mem_rvalid_i = 0;
        @(negedge clk);
        req_valid_i = 1'b0;
        #1;
        chk("midrst.req_before", 64'(mif.mem_req_o), 64'd1);
        rst = 1'b0;
        #1;
        chk("midrst.ready", 64'(req_ready_o), 64'd1);
        chk("midrst.mem_req", 64'(mif.mem_req_o), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        run64("ld",  2'd3, 0, 32'h8, 64'h8000_0000_0000_0001, 8'hFF, 64'h8000_0000_0000_0001);
        run64("lw64", 2'd2, 0, 32'h4, 64'h8000_0000_0000_0001, 8'hF0, 64'hFFFF_FFFF_8000_0000);
        run64("lbu64", 2'd0, 1, 32'hF, 64'h8000_0000_0000_0001, 8'h80, 64'h0000_0000_0000_0080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised load/store unit that replaces the fixed single-cycle synchronous data-memory path of the MEM stage.
- Talks to an external data memory over a req/gnt/rvalid handshake with variable latency.
- Generates byte enables and aligned write data, and sign- or zero-extends load data.
- Flags misaligned accesses and memory timeouts, and stalls the pipeline while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, memory/register data width; legal values 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- TIMEOUT, 16, maximum cycles from grant to rvalid before a bus error is raised; must be at least 1.
- RD_BITS, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- req_valid_i  in  1  pipeline presents a memory operation
- req_ready_o  out  1  unit accepts an operation this cycle
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double (legal only when DATA_WIDTH = 64)
- req_unsigned_i  in  1  load zero-extends when 1
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  store data, right-justified
- req_rd_i  in  RD_BITS  load destination register
- flush_i  in  1  kill the in-flight operation
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  DATA_WIDTH/8  byte enables
- mem_addr_o  out  ADDR_WIDTH  address aligned to DATA_WIDTH/8
- mem_wdata_o  out  DATA_WIDTH  lane-shifted store data
- mem_gnt_i  in  1  memory accepted the request
- mem_rvalid_i  in  1  response valid
- mem_rdata_i  in  DATA_WIDTH  raw read word
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  DATA_WIDTH  extended load result; 0 for stores
- resp_rd_o  out  RD_BITS  destination of the completed load
- misalign_o  out  1  pulse: request rejected as misaligned or illegal size
- bus_err_o  out  1  pulse: timeout expired
- stall_o  out  1  pipeline must hold

Behaviour:
- Reset (rst = 0): state IDLE; all outputs 0 except req_ready_o = 1.
- FSM states and transitions:
  - IDLE: req_ready_o = 1. On req_valid_i:
    - If addr is not a multiple of 2^size, or size = 3 with DATA_WIDTH = 32: pulse misalign_o next cycle, issue no memory request, stay IDLE.
    - Otherwise latch the request and go to REQ.
  - REQ: mem_req_o = 1; address, we, be and wdata held stable until mem_gnt_i. On grant go to WAIT and clear the timeout counter.
  - WAIT: the counter increments each cycle.
    - On mem_rvalid_i go to RESP.
    - If the counter reaches TIMEOUT before rvalid: pulse bus_err_o and go to IDLE; a later rvalid for that access is ignored.
  - RESP: pulse resp_valid_o for exactly one cycle, then go to IDLE.
- Latency: grant in the first REQ cycle with rvalid on the cycle after grant gives resp_valid_o 3 cycles after acceptance.
- stall_o = 1 in REQ, WAIT and RESP. req_ready_o = 1 only in IDLE, so the unit never holds more than one outstanding operation.
- Byte enables: mem_be_o = ((1 << 2^size) - 1) << addr[log2(DATA_WIDTH/8)-1:0].
- Write data: mem_wdata_o = req_wdata_i << (8 × lane offset).
- Load data: the rdata word is shifted right by the lane offset, then sign- or zero-extended from 8, 16 or 32 bits. Word loads on DATA_WIDTH = 64 also extend.
- Stores: the response is still signalled on rvalid. resp_rdata_o = 0 and resp_rd_o = 0.
- flush_i:
  - In REQ before grant: drop the request and go to IDLE.
  - In WAIT: go to a DRAIN state that swallows the pending rvalid without a response, then go to IDLE. A timeout in DRAIN also returns to IDLE, with no bus_err.
  - In RESP: suppress resp_valid_o.
- Simultaneous events:
  - mem_gnt_i and flush_i in the same REQ cycle: treat as granted, go to DRAIN.
  - rvalid on the same cycle the counter hits TIMEOUT: rvalid wins.
- Reset mid-operation aborts immediately to IDLE; the memory side is required to tolerate the abandoned request.

Test Plan:
- Aligned loads, DATA_WIDTH = 32, rdata = 0x80F1_7F82:
  - lb @0x100 → 0xFFFF_FF82
  - lbu @0x101 → 0x0000_007F
  - lh @0x102 → 0xFFFF_80F1
  - lw @0x100 → 0x80F1_7F82
  - gnt and rvalid immediate, resp_valid_o 3 cycles after acceptance.
- Stores: sb 0xAB @0x103 → mem_be_o = 4'b1000, mem_wdata_o = 0xAB00_0000. sh 0x1234 @0x102 → be = 4'b1100, wdata = 0x1234_0000.
- Misalignment: lw @0x102 → misalign_o pulse, mem_req_o stays 0. Size 3 with DATA_WIDTH = 32 → misalign_o.
- Variable latency: hold gnt low 3 cycles, then rvalid 5 cycles after grant → mem_req_o stable throughout, stall_o high until resp, exactly one resp_valid_o.
- Timeout, TIMEOUT = 4: grant, never rvalid → bus_err_o pulses on the 4th WAIT cycle, then IDLE. A subsequent load completes normally.
- Flush during WAIT: a late rvalid produces no resp_valid_o. DATA_WIDTH = 64: ld @0x8 on rdata 0x8000_0000_0000_0001 → 0x8000_0000_0000_0001, be = 8'hFF.
